// File: rtl/uart_host_rx.sv
// uart_host_rx: host-side 8N1 UART receiver (LSB first) feeding a show-ahead byte FIFO.
//   clk       in   testbench clock, rising edge
//   rst       in   asynchronous active-high reset
//   rx        in   serial line, idle high
//   rd_en     in   pop head byte (ignored when empty)
//   rd_data   out  FIFO head byte; last popped byte while empty
//   empty     out  FIFO holds no bytes
//   full      out  FIFO holds FIFO_DEPTH bytes
//   frame_err out  one-cycle pulse when the stop bit is sampled low
//   overflow  out  sticky: a byte was dropped on a full FIFO
module uart_host_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overflow
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t r_state, w_next;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic [7:0]    r_last;
  logic          w_rx_s, w_tick, w_push, w_pop, w_wr;
  assign w_rx_s  = r_sync[1];
  assign w_tick  = r_cnt == '0;
  assign w_push  = r_state == STOP && w_tick && w_rx_s;
  assign empty   = r_count == '0;
  assign full    = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_pop   = rd_en && !empty;
  // a simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign w_wr    = w_push && (!full || w_pop);
  assign rd_data = empty ? r_last : r_mem[r_rd];
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_rx_s) w_next = START;
      START:   if (w_tick) w_next = w_rx_s ? IDLE : DATA;
      DATA:    if (w_tick && r_idx == 3'd7) w_next = STOP;
      STOP:    if (w_tick) w_next = w_rx_s ? IDLE : BRK;
      BRK:     if (w_rx_s) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      frame_err <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], rx};
      frame_err <= r_state == STOP && w_tick && !w_rx_s;
      // IDLE keeps the half-bit count preloaded so START lands mid start bit
      r_cnt     <= r_state == IDLE ? CW'(CLKS_PER_BIT/2 - 1) :
                   w_tick ? CW'(CLKS_PER_BIT - 1) : r_cnt - 1'b1;
      if (r_state == START) r_idx <= '0;
      if (r_state == DATA && w_tick) begin
        r_shift[r_idx] <= w_rx_s;
        r_idx          <= r_idx + 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr] <= r_shift;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_last   <= '0;
      overflow <= 1'b0;
    end else begin
      r_wr    <= r_wr + AW'(w_wr);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      if (w_pop) r_last <= r_mem[r_rd];
      if (w_push && full && !w_pop) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_uart_host_rx.sv
// tb_uart_host_rx: randomized and directed checks of uart_host_rx against a queue model.
module tb_uart_host_rx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  logic       clk = 0, rst = 1, rx = 1, rd_en = 0;
  logic [7:0] rd_data;
  logic       empty, full, frame_err, overflow;
  int         errors = 0, checks = 0, fe_cnt = 0, fall_cnt = 0;
  logic       empty_q = 1;
  logic [7:0] q[$];
  logic [7:0] last = 0;
  bit         ovf = 0;
  uart_host_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .frame_err(frame_err), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (empty_q && !empty) fall_cnt++;
    empty_q = empty;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cmp_all(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    check({tag, ".rd_data"}, 32'(rd_data), 32'(q.size() != 0 ? q[0] : last));
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    rx = 0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic idle(input int n);
    rx = 1;
    repeat (n) @(negedge clk);
  endtask
  task automatic mpush(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else ovf = 1;
  endtask
  task automatic mpop();
    if (q.size() != 0) last = q.pop_front();
  endtask
  task automatic pop();
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    mpop();
  endtask
  task automatic do_reset(input string tag);
    rst = 1;
    rx  = 1;
    repeat (3) @(negedge clk);
    q.delete();
    last = 0;
    ovf  = 0;
    cmp_all(tag);
    rst = 0;
    idle(2);
  endtask
  initial begin
    int fb, fe;
    @(negedge clk);
    do_reset("reset");
    fb = fall_cnt; fe = fe_cnt;
    send(8'h41, 1); idle(CPB); mpush(8'h41);
    cmp_all("t1");
    check("t1.falls", 32'(fall_cnt - fb), 1);
    pop(); cmp_all("t1.pop");
    check("t1.frame_err", 32'(fe_cnt - fe), 0);
    send(8'h48, 1); send(8'h69, 1); idle(CPB);
    mpush(8'h48); mpush(8'h69);
    cmp_all("t2");
    pop(); cmp_all("t2.pop1");
    pop(); cmp_all("t2.pop2");
    rx = 0; @(negedge clk); idle(3 * CPB);
    cmp_all("t3");
    fe = fe_cnt;
    send(8'h55, 0);
    repeat (3 * CPB) @(negedge clk);
    idle(CPB);
    send(8'hA5, 1); idle(CPB); mpush(8'hA5);
    check("t4.frame_err", 32'(fe_cnt - fe), 1);
    cmp_all("t4");
    pop(); cmp_all("t4.pop");
    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 1); idle(CPB); mpush(8'(b));
      if (b >= 4) cmp_all($sformatf("t5.fill%0d", b));
    end
    for (int b = 1; b <= 4; b++) begin
      pop(); cmp_all($sformatf("t5.pop%0d", b));
    end
    do_reset("t5b.reset");
    for (int b = 1; b <= 4; b++) begin
      send(8'(b), 1); idle(CPB); mpush(8'(b));
    end
    cmp_all("t5b.full");
    fork
      send(8'h05, 1);
      begin
        repeat (39) @(negedge clk);
        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
      end
    join
    mpop(); mpush(8'h05);
    idle(CPB);
    cmp_all("t5b.pushpop");
    for (int b = 0; b < 4; b++) begin
      pop(); cmp_all($sformatf("t5b.pop%0d", b));
    end
    fe = fe_cnt;
    rx = 0; repeat (CPB) @(negedge clk);
    rx = 0; repeat (CPB) @(negedge clk);
    rx = 0; repeat (CPB) @(negedge clk);
    rx = 1; repeat (2) @(negedge clk);
    rst = 1; rx = 1;
    repeat (3) @(negedge clk);
    check("t6.empty_in_rst", 32'(empty), 1);
    rst = 0; q.delete(); last = 0; ovf = 0;
    idle(2 * CPB);
    send(8'hC3, 1); idle(CPB); mpush(8'hC3);
    cmp_all("t6");
    check("t6.frame_err", 32'(fe_cnt - fe), 0);
    pop(); cmp_all("t6.pop");
    fe = fe_cnt;
    begin
      int exp_fe = 0;
      for (int n = 0; n < 24; n++) begin
        logic [7:0] b;
        logic good;
        b = 8'($urandom);
        good = $urandom_range(0, 9) != 0;
        send(b, good);
        if (good) mpush(b);
        else exp_fe++;
        idle($urandom_range(CPB, 3 * CPB));
        cmp_all($sformatf("rnd%0d", n));
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          pop(); cmp_all($sformatf("rnd%0d.pop", n));
        end
      end
      check("rnd.frame_err", 32'(fe_cnt - fe), 32'(exp_fe));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
